// File: rtl/wb_regfile_writer_pkg.sv
// Shared lc3b write-back types: select encoding, condition-code word and the WB pipeline register layout.
package wb_regfile_writer_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_BYTE = 2'd2,
        WB_PC   = 2'd3
    } lc3b_wbsel;

    typedef logic [2:0]  lc3b_nzp;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    localparam lc3b_reg R7       = 3'b111;
    localparam lc3b_nzp CC_RESET = 3'b010;

    typedef struct packed {
        logic      valid;
        lc3b_word  alu_out;
        lc3b_word  rdata;
        lc3b_word  pc;
        lc3b_reg   dest;
        logic      trap;
        lc3b_wbsel wbsel;
        logic      byte_hi;
        logic      load_reg;
        logic      load_cc;
    } wb_reg_t;

    function automatic lc3b_nzp gen_nzp(input lc3b_word v);
        return {v[15], (v == 16'h0000), (~v[15]) & (v != 16'h0000)};
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters for RAW hazard detection in ID.
// Lookups see the counters before this cycle's issue/retire update.
module wb_scoreboard
    import wb_regfile_writer_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int PEND_W   = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    inc_en,
    input  lc3b_reg inc_reg,
    input  logic    dec_en,
    input  lc3b_reg dec_reg,
    input  lc3b_reg query_a,
    input  lc3b_reg query_b,
    output logic    busy_a,
    output logic    busy_b,
    output logic    overflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_d [NUM_REGS];
    logic              overflow_q;
    logic              overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            // Issue and retire of the same register cancel out.
            if (inc_en && (inc_reg == lc3b_reg'(r)) && !(dec_en && (dec_reg == lc3b_reg'(r)))) begin
                if (cnt_q[r] == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + PEND_W'(1);
                end
            end else if (dec_en && (dec_reg == lc3b_reg'(r)) && !(inc_en && (inc_reg == lc3b_reg'(r)))) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - PEND_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            overflow_q <= overflow_d;
        end
    end

    assign busy_a   = (cnt_q[query_a] != '0);
    assign busy_b   = (cnt_q[query_b] != '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/wb_regfile_writer.sv
// lc3b write-back stage: WB pipeline register, write-back mux, regfile write port,
// condition codes and the pending-write scoreboard used by ID.
module wb_regfile_writer
    import wb_regfile_writer_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int PEND_W   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_stall,
    input  logic        mem_valid,
    input  logic [15:0] mem_alu_out,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] mem_pc,
    input  logic [2:0]  mem_dest,
    input  logic        mem_trap,
    input  logic [1:0]  mem_wbsel,
    input  logic        mem_byte_hi,
    input  logic        mem_load_reg,
    input  logic        mem_load_cc,
    input  logic        id_issue,
    input  logic [2:0]  id_issue_dest,
    input  logic [2:0]  id_query_a,
    input  logic [2:0]  id_query_b,
    output logic [15:0] regfilemux_out,
    output logic [2:0]  dest,
    output logic        load_regfile,
    output logic [2:0]  cc_nzp,
    output logic        busy_a,
    output logic        busy_b,
    output logic        sb_overflow
);

    wb_reg_t  wb_q;
    wb_reg_t  wb_d;
    lc3b_nzp  cc_q;
    lc3b_nzp  cc_d;
    logic     fire;
    logic [7:0] byte_sel;

    always_comb begin
        wb_d = wb_q;
        if (!wb_stall) begin
            wb_d.valid    = mem_valid;
            wb_d.alu_out  = mem_alu_out;
            wb_d.rdata    = mem_rdata;
            wb_d.pc       = mem_pc;
            wb_d.dest     = mem_dest;
            wb_d.trap     = mem_trap;
            wb_d.wbsel    = lc3b_wbsel'(mem_wbsel);
            wb_d.byte_hi  = mem_byte_hi;
            wb_d.load_reg = mem_load_reg;
            wb_d.load_cc  = mem_load_cc;
        end
    end

    always_comb begin
        byte_sel = wb_q.byte_hi ? wb_q.rdata[15:8] : wb_q.rdata[7:0];
        case (wb_q.wbsel)
            WB_ALU:  regfilemux_out = wb_q.alu_out;
            WB_MEM:  regfilemux_out = wb_q.rdata;
            WB_BYTE: regfilemux_out = {8'h00, byte_sel};
            WB_PC:   regfilemux_out = wb_q.pc;
            default: regfilemux_out = wb_q.alu_out;
        endcase
    end

    // A stalled instruction stays in WB and commits once, on the first unstalled edge.
    assign fire         = wb_q.valid & ~wb_stall;
    assign load_regfile = fire & wb_q.load_reg;
    assign dest         = wb_q.trap ? R7 : wb_q.dest;

    always_comb begin
        cc_d = cc_q;
        if (fire && wb_q.load_cc) begin
            cc_d = gen_nzp(regfilemux_out);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_q <= '0;
            cc_q <= CC_RESET;
        end else begin
            wb_q <= wb_d;
            cc_q <= cc_d;
        end
    end

    assign cc_nzp = cc_q;

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc_en   (id_issue),
        .inc_reg  (id_issue_dest),
        .dec_en   (load_regfile),
        .dec_reg  (dest),
        .query_a  (id_query_a),
        .query_b  (id_query_b),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .overflow (sb_overflow)
    );

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Directed bench for wb_regfile_writer: inputs change and outputs are sampled on the falling edge.
module tb_wb_regfile_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_stall;
    logic        mem_valid;
    logic [15:0] mem_alu_out;
    logic [15:0] mem_rdata;
    logic [15:0] mem_pc;
    logic [2:0]  mem_dest;
    logic        mem_trap;
    logic [1:0]  mem_wbsel;
    logic        mem_byte_hi;
    logic        mem_load_reg;
    logic        mem_load_cc;
    logic        id_issue;
    logic [2:0]  id_issue_dest;
    logic [2:0]  id_query_a;
    logic [2:0]  id_query_b;
    logic [15:0] regfilemux_out;
    logic [2:0]  dest;
    logic        load_regfile;
    logic [2:0]  cc_nzp;
    logic        busy_a;
    logic        busy_b;
    logic        sb_overflow;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    wb_regfile_writer #(.NUM_REGS(8), .PEND_W(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb_stall       (wb_stall),
        .mem_valid      (mem_valid),
        .mem_alu_out    (mem_alu_out),
        .mem_rdata      (mem_rdata),
        .mem_pc         (mem_pc),
        .mem_dest       (mem_dest),
        .mem_trap       (mem_trap),
        .mem_wbsel      (mem_wbsel),
        .mem_byte_hi    (mem_byte_hi),
        .mem_load_reg   (mem_load_reg),
        .mem_load_cc    (mem_load_cc),
        .id_issue       (id_issue),
        .id_issue_dest  (id_issue_dest),
        .id_query_a     (id_query_a),
        .id_query_b     (id_query_b),
        .regfilemux_out (regfilemux_out),
        .dest           (dest),
        .load_regfile   (load_regfile),
        .cc_nzp         (cc_nzp),
        .busy_a         (busy_a),
        .busy_b         (busy_b),
        .sb_overflow    (sb_overflow)
    );

    task automatic set_mem(input logic v, input logic [15:0] alu, input logic [15:0] rd,
                           input logic [15:0] pc, input logic [2:0] d, input logic tr,
                           input logic [1:0] sel, input logic bh, input logic lr, input logic lc);
        mem_valid    = v;
        mem_alu_out  = alu;
        mem_rdata    = rd;
        mem_pc       = pc;
        mem_dest     = d;
        mem_trap     = tr;
        mem_wbsel    = sel;
        mem_byte_hi  = bh;
        mem_load_reg = lr;
        mem_load_cc  = lc;
    endtask

    task automatic idle();
        set_mem(1'b0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wb_stall = 1'b0;
        id_issue = 1'b0;
        id_issue_dest = 3'd0;
        id_query_a = 3'd0;
        id_query_b = 3'd1;
        idle();
        @(negedge clk);
        @(negedge clk);
        checks++; if (load_regfile !== 1'b0) $display("FAIL rst_load: got %b want 0", load_regfile); else passed++;
        checks++; if (regfilemux_out !== 16'h0000) $display("FAIL rst_mux: got %h want 0000", regfilemux_out); else passed++;
        checks++; if (dest !== 3'd0) $display("FAIL rst_dest: got %0d want 0", dest); else passed++;
        checks++; if (cc_nzp !== 3'b010) $display("FAIL rst_cc: got %b want 010", cc_nzp); else passed++;
        checks++; if (sb_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", sb_overflow); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (load_regfile !== 1'b0) $display("FAIL rel_load: got %b want 0", load_regfile); else passed++;
        checks++; if (cc_nzp !== 3'b010) $display("FAIL rel_cc: got %b want 010", cc_nzp); else passed++;
        checks++; if ({busy_a, busy_b} !== 2'b00) $display("FAIL rel_busy: got %b want 00", {busy_a, busy_b}); else passed++;
    endtask

    task automatic test_alu_cc();
        set_mem(1'b1, 16'h8001, 16'h0, 16'h0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        checks++; if (regfilemux_out !== 16'h8001) $display("FAIL alu_mux: got %h want 8001", regfilemux_out); else passed++;
        checks++; if (dest !== 3'd3) $display("FAIL alu_dest: got %0d want 3", dest); else passed++;
        checks++; if (load_regfile !== 1'b1) $display("FAIL alu_load: got %b want 1", load_regfile); else passed++;
        checks++; if (cc_nzp !== 3'b010) $display("FAIL alu_cc_early: got %b want 010", cc_nzp); else passed++;
        @(negedge clk);
        checks++; if (cc_nzp !== 3'b100) $display("FAIL alu_cc: got %b want 100", cc_nzp); else passed++;
        checks++; if (load_regfile !== 1'b0) $display("FAIL alu_load_after: got %b want 0", load_regfile); else passed++;
    endtask

    task automatic test_byte();
        set_mem(1'b1, 16'h0, 16'hA55A, 16'h0, 3'd1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (regfilemux_out !== 16'h00A5) $display("FAIL byte_hi: got %h want 00a5", regfilemux_out); else passed++;
        checks++; if (load_regfile !== 1'b1) $display("FAIL byte_load: got %b want 1", load_regfile); else passed++;
        set_mem(1'b1, 16'h0, 16'hA55A, 16'h0, 3'd1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        checks++; if (regfilemux_out !== 16'h005A) $display("FAIL byte_lo: got %h want 005a", regfilemux_out); else passed++;
        @(negedge clk);
        checks++; if (cc_nzp !== 3'b100) $display("FAIL byte_cc_hold: got %b want 100", cc_nzp); else passed++;
        set_mem(1'b1, 16'h0, 16'h1234, 16'h0, 3'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        checks++; if (regfilemux_out !== 16'h1234) $display("FAIL mem_word: got %h want 1234", regfilemux_out); else passed++;
        @(negedge clk);
    endtask

    task automatic test_cc();
        set_mem(1'b1, 16'h0000, 16'h0, 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (load_regfile !== 1'b0) $display("FAIL cc_noload: got %b want 0", load_regfile); else passed++;
        set_mem(1'b1, 16'h1234, 16'h0, 16'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle();
        checks++; if (cc_nzp !== 3'b010) $display("FAIL cc_zero: got %b want 010", cc_nzp); else passed++;
        @(negedge clk);
        checks++; if (cc_nzp !== 3'b001) $display("FAIL cc_pos: got %b want 001", cc_nzp); else passed++;
    endtask

    task automatic test_trap();
        set_mem(1'b1, 16'h0, 16'h0, 16'h0204, 3'd2, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        checks++; if (dest !== 3'd7) $display("FAIL trap_dest: got %0d want 7", dest); else passed++;
        checks++; if (regfilemux_out !== 16'h0204) $display("FAIL trap_mux: got %h want 0204", regfilemux_out); else passed++;
        checks++; if (load_regfile !== 1'b1) $display("FAIL trap_load: got %b want 1", load_regfile); else passed++;
        @(negedge clk);
        checks++; if (cc_nzp !== 3'b001) $display("FAIL trap_cc_hold: got %b want 001", cc_nzp); else passed++;
    endtask

    task automatic test_stall();
        id_query_a = 3'd2;
        id_issue = 1'b1;
        id_issue_dest = 3'd2;
        @(negedge clk);
        @(negedge clk);
        id_issue = 1'b0;
        set_mem(1'b1, 16'h0000, 16'h0, 16'h0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        wb_stall = 1'b1;
        set_mem(1'b1, 16'hFFFF, 16'h0, 16'h0, 3'd5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (load_regfile !== 1'b0) $display("FAIL stall_load0: got %b want 0", load_regfile); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (load_regfile !== 1'b0) $display("FAIL stall_load[%0d]: got %b want 0", i, load_regfile); else passed++;
            checks++; if ({dest, regfilemux_out} !== {3'd2, 16'h0000}) $display("FAIL stall_hold[%0d]: got %0d/%h want 2/0000", i, dest, regfilemux_out); else passed++;
            checks++; if (cc_nzp !== 3'b001) $display("FAIL stall_cc[%0d]: got %b want 001", i, cc_nzp); else passed++;
        end
        wb_stall = 1'b0;
        idle();
        #1;
        checks++; if (load_regfile !== 1'b1) $display("FAIL stall_release: got %b want 1", load_regfile); else passed++;
        @(negedge clk);
        checks++; if (load_regfile !== 1'b0) $display("FAIL stall_one_pulse: got %b want 0", load_regfile); else passed++;
        checks++; if (busy_a !== 1'b1) $display("FAIL stall_cnt1: got %b want 1", busy_a); else passed++;
        checks++; if (cc_nzp !== 3'b010) $display("FAIL stall_cc_fire: got %b want 010", cc_nzp); else passed++;
        set_mem(1'b1, 16'h0, 16'h0, 16'h0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) $display("FAIL stall_cnt0: got %b want 0", busy_a); else passed++;
    endtask

    task automatic test_scoreboard();
        id_query_a = 3'd4;
        id_query_b = 3'd5;
        id_issue = 1'b1;
        id_issue_dest = 3'd4;
        repeat (3) @(negedge clk);
        id_issue = 1'b0;
        checks++; if ({busy_a, busy_b} !== 2'b10) $display("FAIL sb_busy3: got %b want 10", {busy_a, busy_b}); else passed++;
        checks++; if (sb_overflow !== 1'b0) $display("FAIL sb_ovf_early: got %b want 0", sb_overflow); else passed++;
        id_issue = 1'b1;
        @(negedge clk);
        id_issue = 1'b0;
        checks++; if (sb_overflow !== 1'b1) $display("FAIL sb_ovf: got %b want 1", sb_overflow); else passed++;
        // retire R4 while issuing R4 again: count must stay 3
        set_mem(1'b1, 16'h0, 16'h0, 16'h0, 3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        checks++; if ({load_regfile, dest} !== {1'b1, 3'd4}) $display("FAIL sb_retire4: got %b/%0d want 1/4", load_regfile, dest); else passed++;
        id_issue = 1'b1;
        id_query_b = 3'd1;
        @(negedge clk);
        id_issue = 1'b0;
        checks++; if (busy_a !== 1'b1) $display("FAIL sb_same_cycle: got %b want 1", busy_a); else passed++;
        // three back-to-back retires drain 3 -> 0; R1 issued alongside
        set_mem(1'b1, 16'h0, 16'h0, 16'h0, 3'd4, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (busy_a !== 1'b1) $display("FAIL sb_drain3: got %b want 1", busy_a); else passed++;
        id_issue = 1'b1;
        id_issue_dest = 3'd1;
        @(negedge clk);
        id_issue = 1'b0;
        checks++; if (busy_a !== 1'b1) $display("FAIL sb_drain2: got %b want 1", busy_a); else passed++;
        checks++; if (busy_b !== 1'b1) $display("FAIL sb_indep_r1: got %b want 1", busy_b); else passed++;
        @(negedge clk);
        idle();
        checks++; if ({busy_a, load_regfile} !== 2'b11) $display("FAIL sb_drain1: got %b want 11", {busy_a, load_regfile}); else passed++;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) $display("FAIL sb_drain0: got %b want 0", busy_a); else passed++;
        // retire R5 with nothing pending: no underflow
        id_query_b = 3'd5;
        set_mem(1'b1, 16'h0, 16'h0, 16'h0, 3'd5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        checks++; if ({load_regfile, dest} !== {1'b1, 3'd5}) $display("FAIL sb_retire5: got %b/%0d want 1/5", load_regfile, dest); else passed++;
        @(negedge clk);
        checks++; if (busy_b !== 1'b0) $display("FAIL sb_underflow: got %b want 0", busy_b); else passed++;
        id_issue = 1'b1;
        id_issue_dest = 3'd5;
        @(negedge clk);
        id_issue = 1'b0;
        checks++; if (busy_b !== 1'b1) $display("FAIL sb_r5_issue: got %b want 1", busy_b); else passed++;
        set_mem(1'b1, 16'h0, 16'h0, 16'h0, 3'd5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (busy_b !== 1'b0) $display("FAIL sb_r5_retire: got %b want 0", busy_b); else passed++;
    endtask

    task automatic test_async_reset();
        // R1 still has one pending write from the scoreboard test
        id_query_a = 3'd1;
        set_mem(1'b1, 16'h8000, 16'h0, 16'h0, 3'd6, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({cc_nzp, load_regfile, busy_a} !== 5'b100_1_1) $display("FAIL ar_pre: got %b want 10011", {cc_nzp, load_regfile, busy_a}); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (load_regfile !== 1'b0) $display("FAIL ar_load: got %b want 0", load_regfile); else passed++;
        checks++; if ({regfilemux_out, dest} !== 19'h0) $display("FAIL ar_wb: got %h/%0d want 0000/0", regfilemux_out, dest); else passed++;
        checks++; if (cc_nzp !== 3'b010) $display("FAIL ar_cc: got %b want 010", cc_nzp); else passed++;
        checks++; if ({busy_a, sb_overflow} !== 2'b00) $display("FAIL ar_sb: got %b want 00", {busy_a, sb_overflow}); else passed++;
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({load_regfile, busy_a, cc_nzp} !== 5'b0_0_010) $display("FAIL ar_after: got %b want 00010", {load_regfile, busy_a, cc_nzp}); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu_cc();
        test_byte();
        test_cc();
        test_trap();
        test_stall();
        test_scoreboard();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-back stage of the lc3b pipeline and the writer side of the register file.
- Registers the MEM-stage result and selects the write-back value: ALU result, memory word, zero-extended memory byte, or link PC.
- Drives the regfile write port: data, dest and load. TRAP forces the destination to R7.
- Also owns the condition-code register and a per-register pending-write scoreboard that ID queries for read-after-write (RAW) hazards.

Parameters:
NUM_REGS, 8, number of architectural registers tracked by the scoreboard
PEND_W, 2, width of each per-register pending-write counter

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
wb_stall  in  1  hold the WB register; suppress write and CC update
mem_valid  in  1  MEM stage presents a retiring instruction
mem_alu_out  in  16  ALU/address result
mem_rdata  in  16  data memory read word
mem_pc  in  16  PC+2 for JSR/TRAP link
mem_dest  in  3  IR destination register
mem_trap  in  1  force destination to R7
mem_wbsel  in  2  0=alu, 1=mem word, 2=mem byte, 3=pc
mem_byte_hi  in  1  address bit 0, selects high byte for wbsel=2
mem_load_reg  in  1  instruction writes a register
mem_load_cc  in  1  instruction sets CC
id_issue  in  1  ID issues an instruction that will write a register
id_issue_dest  in  3  its destination (already R7-resolved)
id_query_a  in  3  ID source A
id_query_b  in  3  ID source B
regfilemux_out  out  16  regfile write data
dest  out  3  regfile write address
load_regfile  out  1  regfile write enable
cc_nzp  out  3  condition codes {n,z,p}
busy_a  out  1  source A has a pending write
busy_b  out  1  source B has a pending write
sb_overflow  out  1  sticky: issue attempted on a saturated counter

Behaviour:
- The design has one clock. Reset is asynchronous and active-low.
- While reset_n=0:
  - WB register fields = 0 and wb_valid=0, so load_regfile=0, regfilemux_out=0, dest=0.
  - All scoreboard counters = 0, busy_a=busy_b=0.
  - cc_nzp=3'b010.
  - sb_overflow=0.
- WB register:
  - On posedge clk with wb_stall=0, capture all mem_* fields and set wb_valid=mem_valid.
  - With wb_stall=1, hold all fields.
- Write-back data mux (combinational from the WB register):
  - wbsel 0 = alu_out.
  - wbsel 1 = rdata.
  - wbsel 2 = {8'h00, byte}, where byte = rdata[15:8] if byte_hi else rdata[7:0].
  - wbsel 3 = pc.
- dest = 3'b111 if wb_trap, else wb_dest.
- fire = wb_valid & ~wb_stall.
- load_regfile = fire & wb_load_reg. The regfile commits on the same edge, so each instruction writes exactly once even if stalled.
- Latency: a MEM result captured at edge N is written to the regfile at edge N+1 (no stall).
- CC update:
  - At an edge where fire & wb_load_cc, cc_nzp takes {v[15], v==0, ~v[15] & v!=0}, where v = regfilemux_out.
  - This is independent of wb_load_reg.
  - cc_nzp is otherwise held.
- Scoreboard: cnt[r] is PEND_W bits wide.
  - inc = id_issue for r = id_issue_dest.
  - dec = load_regfile for r = dest.
  - inc & dec on the same r: cnt unchanged.
  - inc only: cnt+1 if cnt < max. If cnt = max, cnt holds and sb_overflow sets; it clears only on reset.
  - dec only: cnt-1 if cnt > 0. If cnt = 0, it stays 0 (no underflow, no flag).
  - inc and dec on different registers apply independently in the same cycle.
- busy_x = (cnt[id_query_x] != 0) | (load_regfile & dest==id_query_x & cnt==0 is impossible) → simplified rule: busy_x = cnt[id_query_x] != 0.
  - busy_x is evaluated on current counter values, before that cycle's update. A register retiring this cycle therefore still reads busy.
  - ID resolves this by regfile write-through or a one-cycle hold; this block does not forward.
- wb_stall has no effect on the scoreboard's issue path.
- Reset mid-operation drops the in-flight write and clears all pending counts.

Decomposition:
- lc3b_types additions:
  - lc3b_wbsel enum {WB_ALU, WB_MEM, WB_BYTE, WB_PC}.
  - lc3b_nzp (3-bit).
  - constant R7 = 3'b111.
  - CC_RESET = 3'b010.
- Sub-module: wb_scoreboard, containing the counters, busy lookup and overflow flag.
- The mux and CC logic stay in the top module, reusing the existing mux2/zext style cells.

Test Plan:
- Reset release: check load_regfile=0, cc_nzp=010, busy_a=busy_b=0 before the first valid.
- Write-back select and CC:
  - mem_wbsel=0, alu_out=16'h8001, dest=3, load_reg=1, load_cc=1 → next cycle regfilemux_out=8001, dest=3, load_regfile=1.
  - After that edge, cc_nzp=100.
- Byte load: mem_rdata=16'hA55A, wbsel=2.
  - byte_hi=1 → regfilemux_out=00A5.
  - byte_hi=0 → regfilemux_out=005A.
- TRAP link: mem_trap=1, mem_dest=2, wbsel=3, pc=16'h0204 → dest=7, regfilemux_out=0204.
- Stall: assert wb_stall for 3 cycles with a valid write pending.
  - load_regfile=0 throughout.
  - On release, exactly one load_regfile pulse.
  - cnt[dest] decrements once.
- Scoreboard:
  - Issue R4 three times (PEND_W=2): cnt=3, busy on query 4.
  - A 4th issue with no retire → sb_overflow=1 and cnt stays 3.
  - Simultaneous issue and retire of R4 → cnt unchanged.
  - Retire R5 with cnt=0 → stays 0.
